// File: rtl/ifetch_refill_if.sv
// Fetch-side bundle of ifetch_refill: core fetch port, instruction-cache port and
// arbiter/memory port. master = the refill engine, slave = its surroundings.
interface ifetch_refill_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] pc_in;
  logic             pc_valid;
  logic             stall;
  logic [31:0]      instr_out;
  logic             instr_valid;
  logic             fetch_err;

  logic [WIDTH-1:0] cache_adr;
  logic [31:0]      cache_instr;
  logic             cache_hit;
  logic [31:0]      cache_wdata;
  logic             cache_wen;

  logic             mem_req;
  logic [WIDTH-1:0] mem_adr;
  logic             mem_gnt;
  logic             mem_rvalid;
  logic [31:0]      mem_rdata;

  logic [15:0]      hit_count;
  logic [15:0]      miss_count;

  modport master (
    input  pc_in, pc_valid, cache_instr, cache_hit, mem_gnt, mem_rvalid, mem_rdata,
    output stall, instr_out, instr_valid, fetch_err, cache_adr, cache_wdata, cache_wen,
           mem_req, mem_adr, hit_count, miss_count
  );

  modport slave (
    output pc_in, pc_valid, cache_instr, cache_hit, mem_gnt, mem_rvalid, mem_rdata,
    input  stall, instr_out, instr_valid, fetch_err, cache_adr, cache_wdata, cache_wen,
           mem_req, mem_adr, hit_count, miss_count
  );
endinterface

// File: rtl/ifetch_refill.sv
// Instruction-fetch miss handler: cache lookup, refill from shared memory, retry.
// Define IFETCH_PERF_CNT_EN to build the saturating hit/miss performance counters.
module ifetch_refill #(
  parameter int          WIDTH       = 8,
  parameter int          CACHE_LAT   = 2,
  parameter int          MEM_TIMEOUT = 64,
  parameter logic [31:0] NOP_WORD    = 32'h20000000
) (
  input  logic            clk,
  input  logic            rst_n,
  ifetch_refill_if.master bus
);

  localparam int LW = (CACHE_LAT > 0) ? $clog2(CACHE_LAT + 1) : 1;
  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REQ,
    S_WAIT,
    S_FILL
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [LW-1:0]    lat_q, lat_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [31:0]      data_q, data_d;
  logic [1:0]       fills_q, fills_d;
  logic [31:0]      instr_q, instr_d;
  logic             ivalid_q, ivalid_d;
  logic             err_q, err_d;

  logic lookup_done;
  logic first_hit;
  logic req_entry;

  assign lookup_done = (state_q == S_LOOKUP) && (lat_q == '0);
  assign first_hit   = lookup_done && bus.cache_hit && (fills_q == 2'd0);
  // After two fills that the cache never absorbed, the captured word is delivered directly.
  assign req_entry   = lookup_done && !bus.cache_hit && (fills_q != 2'd2);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    lat_d    = lat_q;
    tmo_d    = tmo_q;
    data_d   = data_q;
    fills_d  = fills_q;
    instr_d  = instr_q;
    ivalid_d = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.pc_valid) begin
          addr_d  = bus.pc_in;
          lat_d   = LW'(CACHE_LAT);
          fills_d = 2'd0;
          state_d = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (lat_q != '0) begin
          lat_d = lat_q - LW'(1);
        end else if (bus.cache_hit) begin
          instr_d  = bus.cache_instr;
          ivalid_d = 1'b1;
          state_d  = S_IDLE;
        end else if (fills_q == 2'd2) begin
          instr_d  = data_q;
          ivalid_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (bus.mem_gnt) begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // A read return on the final timeout cycle still counts as a response.
        if (bus.mem_rvalid) begin
          data_d  = bus.mem_rdata;
          state_d = S_FILL;
        end else if (tmo_q == TW'(MEM_TIMEOUT - 1)) begin
          instr_d  = NOP_WORD;
          ivalid_d = 1'b1;
          err_d    = 1'b1;
          state_d  = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_FILL: begin
        fills_d = fills_q + 2'd1;
        lat_d   = LW'(CACHE_LAT);
        state_d = S_LOOKUP;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      lat_q    <= '0;
      tmo_q    <= '0;
      data_q   <= '0;
      fills_q  <= 2'd0;
      instr_q  <= NOP_WORD;
      ivalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      lat_q    <= lat_d;
      tmo_q    <= tmo_d;
      data_q   <= data_d;
      fills_q  <= fills_d;
      instr_q  <= instr_d;
      ivalid_q <= ivalid_d;
      err_q    <= err_d;
    end
  end

  assign bus.stall       = (state_q != S_IDLE);
  assign bus.instr_out   = instr_q;
  assign bus.instr_valid = ivalid_q;
  assign bus.fetch_err   = err_q;
  assign bus.cache_adr   = addr_q;
  assign bus.cache_wdata = data_q;
  assign bus.cache_wen   = (state_q == S_FILL);
  assign bus.mem_req     = (state_q == S_REQ);
  assign bus.mem_adr     = {addr_q[WIDTH-1:2], 2'b00};

`ifdef IFETCH_PERF_CNT_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (first_hit && (hit_cnt_q != 16'hFFFF)) begin
      hit_cnt_d = hit_cnt_q + 16'd1;
    end
    if (req_entry && (miss_cnt_q != 16'hFFFF)) begin
      miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= 16'd0;
      miss_cnt_q <= 16'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
`else
  logic unused_perf;
  assign unused_perf    = first_hit ^ req_entry;
  assign bus.hit_count  = 16'd0;
  assign bus.miss_count = 16'd0;
`endif

endmodule

// File: tb/tb_ifetch_refill.sv
// Self-checking bench for ifetch_refill: directed vector table, corner sequences and
// randomized fetches checked against a transaction-level fetch model.
module tb_ifetch_refill;

  localparam int          WIDTH       = 8;
  localparam int          CACHE_LAT   = 2;
  localparam int          MEM_TIMEOUT = 64;
  localparam logic [31:0] NOP         = 32'h20000000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ifetch_refill_if #(.WIDTH(WIDTH)) bus ();

  ifetch_refill #(
    .WIDTH      (WIDTH),
    .CACHE_LAT  (CACHE_LAT),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .NOP_WORD   (NOP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Word-addressed direct-mapped cache: 64 lines cover the whole 8-bit space.
  logic        c_valid [64];
  logic [31:0] c_data  [64];
  assign bus.cache_hit   = c_valid[bus.cache_adr[7:2]];
  assign bus.cache_instr = c_data[bus.cache_adr[7:2]];

  int n_cmp    = 0;
  int n_err    = 0;
  int hit_exp  = 0;
  int miss_exp = 0;

  typedef struct {
    logic [7:0]  addr;
    bit          hit;
    logic [31:0] cword;
    int          gdly;      // cycles of mem_req before grant
    int          rdly;      // edges after grant edge that see rvalid; 0 = never
    logic [31:0] mword;
    bit          drop;      // cache ignores fills
    bit          noise;     // pc_in moves to 8'h40 with pc_valid high during the fetch
    logic [31:0] exp_instr;
    bit          exp_err;
    int          exp_reqs;
    int          exp_wens;
    int          exp_lat;   // -1 = not checked
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " stall"},       32'(bus.stall),       32'd0);
    chk({tag, " instr_valid"}, 32'(bus.instr_valid), 32'd0);
    chk({tag, " fetch_err"},   32'(bus.fetch_err),   32'd0);
    chk({tag, " instr_out"},   bus.instr_out,        NOP);
    chk({tag, " cache_wen"},   32'(bus.cache_wen),   32'd0);
    chk({tag, " mem_req"},     32'(bus.mem_req),     32'd0);
    chk({tag, " cache_adr"},   32'(bus.cache_adr),   32'd0);
    chk({tag, " mem_adr"},     32'(bus.mem_adr),     32'd0);
    chk({tag, " hit_count"},   32'(bus.hit_count),   32'd0);
    chk({tag, " miss_count"},  32'(bus.miss_count),  32'd0);
  endtask

  // Fetch outcome from the behavioural rules: hit delivers the cache word; a miss runs
  // up to two refill episodes, each aborting to NOP if memory stays silent too long.
  function automatic void model(inout vec_t v);
    v.exp_instr = NOP;
    v.exp_err   = 1'b0;
    v.exp_reqs  = 0;
    v.exp_wens  = 0;
    v.exp_lat   = -1;
    if (v.hit) begin
      v.exp_instr = v.cword;
      v.exp_lat   = CACHE_LAT + 1;
      return;
    end
    for (int e = 1; e <= 2; e++) begin
      v.exp_reqs++;
      if (v.rdly == 0 || v.rdly > MEM_TIMEOUT) begin
        v.exp_err   = 1'b1;
        v.exp_instr = NOP;
        return;
      end
      v.exp_wens++;
      v.exp_instr = v.mword;
      if (!v.drop) return;
    end
  endfunction

  // Starts at a negedge with the DUT idle, ends at the negedge showing instr_valid.
  task automatic run_txn(input int id, input vec_t v);
    int          phase, gcnt, rcnt, reqs, wens, lat;
    bit          done, prev_req;
    logic [31:0] got_instr;
    logic        got_err;
    phase = 0; gcnt = 0; rcnt = 0; reqs = 0; wens = 0; lat = -1;
    done = 1'b0; prev_req = 1'b0; got_instr = '0; got_err = 1'b0;

    c_valid[v.addr[7:2]] = v.hit;
    c_data[v.addr[7:2]]  = v.cword;
    bus.pc_in      = v.addr;
    bus.pc_valid   = 1'b1;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;

    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      @(negedge clk);
      if (v.noise) bus.pc_in = 8'h40;
      else         bus.pc_valid = 1'b0;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;

      chk("cache_adr_hold", 32'(bus.cache_adr), 32'(v.addr));
      chk("excl", {30'd0, bus.cache_wen & bus.instr_valid, bus.fetch_err & ~bus.instr_valid}, 32'd0);
      if (bus.instr_valid) begin
        done      = 1'b1;
        lat       = cyc;
        got_instr = bus.instr_out;
        got_err   = bus.fetch_err;
        chk("stall_release", 32'(bus.stall), 32'd0);
      end else begin
        chk("stall_busy", 32'(bus.stall), 32'd1);
      end
      if (bus.cache_wen) begin
        wens++;
        chk("fill_wdata", bus.cache_wdata, v.mword);
        if (!v.drop) begin
          c_valid[bus.cache_adr[7:2]] = 1'b1;
          c_data[bus.cache_adr[7:2]]  = bus.cache_wdata;
        end
      end
      if (bus.mem_req) begin
        chk("mem_adr", 32'(bus.mem_adr), 32'({v.addr[7:2], 2'b00}));
        if (!prev_req) reqs++;
      end
      prev_req = bus.mem_req;

      if (!done) begin
        if (phase == 0 && bus.mem_req) begin
          phase = 1;
          gcnt  = 0;
        end
        if (phase == 1) begin
          if (gcnt >= v.gdly) begin
            bus.mem_gnt = 1'b1;
            phase       = 2;
            rcnt        = 0;
          end else begin
            gcnt++;
          end
        end else if (phase == 2) begin
          rcnt++;
          if (v.rdly != 0 && rcnt == v.rdly) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = v.mword;
            phase          = 0;
          end
        end
      end
    end

    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL txn%0d_timeout: got no instr_valid, expected one within 600 cycles", id);
    end else begin
      chk($sformatf("txn%0d instr", id), got_instr, v.exp_instr);
      chk($sformatf("txn%0d err", id),   32'(got_err), 32'(v.exp_err));
      chk($sformatf("txn%0d reqs", id),  32'(reqs), 32'(v.exp_reqs));
      chk($sformatf("txn%0d wens", id),  32'(wens), 32'(v.exp_wens));
      if (v.exp_lat >= 0) chk($sformatf("txn%0d lat", id), 32'(lat), 32'(v.exp_lat));
    end
    if (v.hit) hit_exp++;
    miss_exp += v.exp_reqs;
`ifdef IFETCH_PERF_CNT_EN
    chk($sformatf("txn%0d hit_count", id),  32'(bus.hit_count),  32'(hit_exp));
    chk($sformatf("txn%0d miss_count", id), 32'(bus.miss_count), 32'(miss_exp));
`else
    chk($sformatf("txn%0d hit_count", id),  32'(bus.hit_count),  32'd0);
    chk($sformatf("txn%0d miss_count", id), 32'(bus.miss_count), 32'd0);
`endif
    $display("txn %0d addr=%h hit=%0d rdly=%0d drop=%0d -> instr=%h err=%0d reqs=%0d wens=%0d lat=%0d",
             id, v.addr, v.hit, v.rdly, v.drop, got_instr, got_err, reqs, wens, lat);
  endtask

  // Miss, grant, then assert rst_n asynchronously while waiting for read data.
  task automatic reset_mid_wait();
    int waitc;
    bit granted;
    waitc = 0;
    granted = 1'b0;
    c_valid[6'd20] = 1'b0;
    bus.pc_in    = 8'h50;
    bus.pc_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      bus.pc_valid = 1'b0;
      bus.mem_gnt  = 1'b0;
      if (granted) begin
        waitc++;
        if (waitc == 10) break;
      end else if (bus.mem_req) begin
        bus.mem_gnt = 1'b1;
        granted     = 1'b1;
      end
    end
    chk("pre_reset stall", 32'(bus.stall), 32'd1);
    chk("pre_reset granted", 32'(granted), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset("async_rst");
    @(negedge clk);
    chk_reset("held_rst");
    rst_n    = 1'b1;
    hit_exp  = 0;
    miss_exp = 0;
    $display("reset mid-WAIT applied at wait cycle %0d", waitc);
  endtask

  vec_t tbl[9];

  initial begin
    vec_t v;
    for (int i = 0; i < 64; i++) begin
      c_valid[i] = 1'b0;
      c_data[i]  = '0;
    end
    bus.pc_in      = '0;
    bus.pc_valid   = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;

    //          addr   hit cword         gdly rdly mword         drop noise exp_instr     err reqs wens lat
    tbl[0] = '{8'h04, 1, 32'h8C010000, 0,   0,   32'h0,        0,   0,    32'h8C010000, 0,  0,   0,   3};
    tbl[1] = '{8'h24, 0, 32'h0,        5,   3,   32'h00221820, 0,   0,    32'h00221820, 0,  1,   1,  -1};
    tbl[2] = '{8'h30, 0, 32'h0,        1,   0,   32'h11111111, 0,   0,    32'h20000000, 1,  1,   0,  -1};
    tbl[3] = '{8'h24, 0, 32'h0,        2,   4,   32'hAAAA5555, 0,   1,    32'hAAAA5555, 0,  1,   1,  -1};
    tbl[4] = '{8'h40, 1, 32'h0BADF00D, 0,   0,   32'h0,        0,   0,    32'h0BADF00D, 0,  0,   0,   3};
    tbl[5] = '{8'h10, 0, 32'h0,        0,   2,   32'h12345678, 1,   0,    32'h12345678, 0,  2,   2,  -1};
    tbl[6] = '{8'h15, 0, 32'h0,        3,  64,   32'hCAFEBABE, 0,   0,    32'hCAFEBABE, 0,  1,   1,  -1};
    tbl[7] = '{8'h18, 0, 32'h0,        0,  65,   32'hDEADBEEF, 0,   0,    32'h20000000, 1,  1,   0,  -1};
    tbl[8] = '{8'h1C, 0, 32'h0,        1,   1,   32'h0F0F0F0F, 1,   0,    32'h0F0F0F0F, 0,  2,   2,  -1};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_txn(i, tbl[i]);

    reset_mid_wait();
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      int r;
      v.addr  = 8'($urandom_range(0, 255));
      v.hit   = ($urandom_range(0, 1) == 1);
      v.cword = $urandom;
      v.gdly  = $urandom_range(0, 6);
      r = $urandom_range(0, 9);
      if (r == 0)      v.rdly = 0;
      else if (r <= 2) v.rdly = $urandom_range(62, 66);
      else             v.rdly = $urandom_range(1, 8);
      v.mword = $urandom;
      v.drop  = ($urandom_range(0, 4) == 0);
      v.noise = 1'b0;
      model(v);
      run_txn(100 + i, v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch_refill.md
Name: ifetch_refill

Overview:
- Fetch-side miss handler between each core's PC logic and its instruction cache (ircache-class, direct-mapped, word-addressed).
- Issues the lookup address to the cache and waits a fixed cache latency for the result.
- On a hit, delivers the instruction.
- On a miss, requests the word from the shared instruction memory through the dual-core arbiter, writes it into the cache, retries the lookup, and stalls the core meanwhile.

Parameters:
- WIDTH, 8, instruction byte-address width (matches cache adr).
- CACHE_LAT, 2, cycles from cache_adr change to valid cache_hit/cache_instr.
- MEM_TIMEOUT, 64, max cycles waiting for mem_rvalid after grant before abort.
- NOP_WORD, 32'h20000000, word presented when no valid instruction.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- pc_in  in  WIDTH  fetch byte address.
- pc_valid  in  1  fetch request, sampled only in IDLE.
- stall  out  1  core must hold PC.
- instr_out  out  32  delivered instruction.
- instr_valid  out  1  one-cycle pulse, instr_out valid.
- fetch_err  out  1  one-cycle pulse with instr_valid on timeout abort.
- cache_adr  out  WIDTH  lookup/fill address to cache.
- cache_instr  in  32  cache read data.
- cache_hit  in  1  cache tag match.
- cache_wdata  out  32  fill data.
- cache_wen  out  1  fill strobe.
- mem_req  out  1  arbiter request.
- mem_adr  out  WIDTH  word-aligned memory address.
- mem_gnt  in  1  arbiter grant.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.
- hit_count  out  16  see Optional Feature.
- miss_count  out  16  see Optional Feature.

Behaviour:
- Reset (async, rst_n=0): state IDLE, stall=0, instr_valid=0, fetch_err=0, instr_out=NOP_WORD, cache_wen=0, mem_req=0, cache_adr=0, mem_adr=0, counters 0.
- Address capture: latched into addr_q in IDLE when pc_valid=1; cache_adr=addr_q; mem_adr={addr_q[WIDTH-1:2],2'b00}. pc_in changes outside IDLE are ignored; the in-flight fetch always completes for addr_q.
- IDLE: on pc_valid, go LOOKUP, stall=1, load latency counter with CACHE_LAT.
- LOOKUP: count down. At 0, sample cache_hit:
  - hit=1: instr_out=cache_instr, instr_valid=1 for one cycle, stall=0, go IDLE. Hit latency = CACHE_LAT+1 cycles from pc_valid to instr_valid.
  - hit=0: go REQ.
- REQ: mem_req=1 held until mem_gnt=1 seen on a posedge; then mem_req=0, timeout counter cleared, go WAIT. The arbiter may hold off the grant indefinitely.
- WAIT: count cycles.
  - mem_rvalid=1: capture mem_rdata, go FILL.
  - Counter reaches MEM_TIMEOUT without rvalid: instr_out=NOP_WORD, instr_valid=1, fetch_err=1 (one cycle), stall=0, go IDLE; no cache write.
  - rvalid and timeout in the same cycle: rvalid wins.
- FILL: cache_wen=1 and cache_wdata=captured word for exactly one cycle, then LOOKUP with counter reloaded (retry).
- Retry miss again (cache failed to take the fill): repeat the miss path. After two consecutive misses on the same address, deliver the captured word directly with instr_valid=1 to guarantee progress.
- Back-to-back: pc_valid held high in the cycle of instr_valid is accepted next cycle (IDLE); no bubble beyond that.
- instr_out holds its last value between pulses; instr_valid, fetch_err and cache_wen are never asserted together except instr_valid+fetch_err.
- stall=1 in every state except IDLE.

Optional Feature:
- Macro IFETCH_PERF_CNT_EN.
- Defined: hit_count increments on each first-lookup hit; miss_count increments on each REQ entry. Both 16-bit, saturating at 16'hFFFF, cleared only by reset.
- Undefined: hit_count and miss_count tied to 0, no counter flops.

Test Plan:
- Reset mid-WAIT (rst_n low at arbitrary cycle) -> next cycle outputs all at reset values, mem_req=0, instr_out=32'h20000000.
- Hit: pc_in=8'h04, pc_valid=1, cache returns hit=1, instr=32'h8C010000 -> instr_valid pulses at cycle 3, instr_out=32'h8C010000, no mem_req, hit_count=1 (macro on).
- Miss: pc_in=8'h24, hit=0, gnt after 5 cycles, rvalid with 32'h00221820 after 3 -> one cache_wen with cache_wdata=32'h00221820 and cache_adr=8'h24; retry hits; instr_valid with same word; miss_count=1.
- Timeout: miss, grant, no rvalid -> after 64 cycles instr_valid=1, fetch_err=1, instr_out=32'h20000000, no cache_wen.
- PC change during miss: pc_in moves 8'h24->8'h40 during WAIT -> fill and delivery use 8'h24; 8'h40 accepted only after return to IDLE.
- Double miss: cache keeps hit=0 after fill of 32'h12345678 -> word delivered directly, exactly two mem_req episodes, then IDLE.
